// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/redirect bus between the in-order pipeline and pipe_hazard_ctrl.
// The pipeline side is the master; the controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 6,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_STAGES-1:0] stall_req_i;
    logic                  jump_enable_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  int_en_i;
    logic [ADDR_WIDTH-1:0] isr_pc_i;
    logic                  pc_valid_i;
    logic [ADDR_WIDTH-1:0] pc_i;

    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] flush_o;
    logic                  redirect_o;
    logic [ADDR_WIDTH-1:0] new_pc_o;
    logic                  jump_pending_o;
    logic [ADDR_WIDTH-1:0] pc_o;

    modport master (
        output stall_req_i, jump_enable_i, jump_addr_i, int_en_i, isr_pc_i, pc_valid_i, pc_i,
        input  stall_o, flush_o, redirect_o, new_pc_o, jump_pending_o, pc_o
    );

    modport slave (
        input  stall_req_i, jump_enable_i, jump_addr_i, int_en_i, isr_pc_i, pc_valid_i, pc_i,
        output stall_o, flush_o, redirect_o, new_pc_o, jump_pending_o, pc_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/redirect controller: stall/flush masks, interrupt and jump
// redirect arbitration with held jumps, mepc tracking, stall watchdog, perf counters.
module pipe_hazard_ctrl #(
    parameter int                  NUM_STAGES       = 6,
    parameter int                  ADDR_WIDTH       = 32,
    parameter int                  JUMP_FLUSH_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                  STALL_TIMEOUT    = 1024,
    parameter int                  CNT_WIDTH        = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pipe_hazard_ctrl_if.slave    bus,
    input  logic                 timeout_clr_i,
    output logic                 stall_timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    function automatic logic [NUM_STAGES-1:0] range_mask(input int lo, input int hi);
        logic [NUM_STAGES-1:0] m;
        for (int i = 0; i < NUM_STAGES; i++) m[i] = (i >= lo) && (i <= hi);
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] INT_FLUSH   = range_mask(1, NUM_STAGES-1);
    localparam logic [NUM_STAGES-1:0] JUMP_FLUSH  = range_mask(1, JUMP_FLUSH_DEPTH);
    localparam logic [NUM_STAGES-1:0] JUMP_UNHOLD = range_mask(0, JUMP_FLUSH_DEPTH);
    // Stages beyond the jump flush window: a hold there would swallow the flushed bubble.
    localparam logic [NUM_STAGES-1:0] DOWNSTREAM  = range_mask(JUMP_FLUSH_DEPTH+1, NUM_STAGES-1);

    localparam int                 WD_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0]    WD_MAX = WD_W'(STALL_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_WIDTH-1:0] last_pc_q, last_pc_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

    logic [NUM_STAGES-1:0] stall_mask;
    logic                  jump_active;
    logic                  jump_blocked;
    logic [ADDR_WIDTH-1:0] jump_tgt;
    logic                  acc;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        acc        = 1'b0;
        stall_mask = '0;
        for (int k = NUM_STAGES-1; k >= 0; k--) begin
            acc           = acc | bus.stall_req_i[k];
            stall_mask[k] = acc;
        end
    end

    // A fresh jump is younger than any held one, so it always takes the target.
    assign jump_active  = bus.jump_enable_i | pend_q;
    assign jump_tgt     = bus.jump_enable_i ? bus.jump_addr_i : pend_addr_q;
    assign jump_blocked = |(bus.stall_req_i & DOWNSTREAM);

    always_comb begin
        bus.stall_o    = stall_mask;
        bus.flush_o    = '0;
        bus.redirect_o = 1'b0;
        bus.new_pc_o   = '0;
        pend_d         = pend_q;
        pend_addr_d    = pend_addr_q;

        if (bus.int_en_i) begin
            bus.stall_o    = '0;
            bus.flush_o    = INT_FLUSH;
            bus.redirect_o = 1'b1;
            bus.new_pc_o   = bus.isr_pc_i;
            pend_d         = 1'b0;
        end else if (jump_active && !jump_blocked) begin
            bus.stall_o    = stall_mask & ~JUMP_UNHOLD;
            bus.flush_o    = JUMP_FLUSH;
            bus.redirect_o = 1'b1;
            bus.new_pc_o   = jump_tgt;
            pend_d         = 1'b0;
        end else if (jump_active) begin
            pend_d      = 1'b1;
            pend_addr_d = jump_tgt;
        end
    end

    assign bus.jump_pending_o = pend_q;
    assign bus.pc_o           = bus.pc_valid_i ? bus.pc_i : last_pc_q;

    always_comb begin
        last_pc_d = last_pc_q;
        if (bus.pc_valid_i)      last_pc_d = bus.pc_i;
        else if (bus.redirect_o) last_pc_d = bus.new_pc_o;
    end

    always_comb begin
        wd_cnt_d    = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.stall_o[0]) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (bus.redirect_o && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);

        timeout_d = timeout_q;
        if (timeout_clr_i || bus.int_en_i)                timeout_d = 1'b0;
        else if (bus.stall_o[0] && wd_cnt_d == WD_MAX)    timeout_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            last_pc_q   <= RESET_PC;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            last_pc_q   <= last_pc_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_timeout_o = timeout_q;
    assign stall_cycles_o  = stall_cnt_q;
    assign flush_count_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle-ordered vector table via a
// scoreboard queue, then hand sequences for reset, watchdog and saturation.
module tb_pipe_hazard_ctrl;

    localparam int NS = 6;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam logic [AW-1:0] RPC = 32'h0000_1000;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          timeout_clr_i;
    logic          stall_timeout_o;
    logic [CW-1:0] stall_cycles_o;
    logic [CW-1:0] flush_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .ADDR_WIDTH(AW)) bus ();

    pipe_hazard_ctrl #(
        .NUM_STAGES(NS), .ADDR_WIDTH(AW), .JUMP_FLUSH_DEPTH(2),
        .RESET_PC(RPC), .STALL_TIMEOUT(4), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .bus(bus),
        .timeout_clr_i(timeout_clr_i),
        .stall_timeout_o(stall_timeout_o),
        .stall_cycles_o(stall_cycles_o),
        .flush_count_o(flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NS-1:0] req;
        logic          jen;
        logic [AW-1:0] jaddr;
        logic          ien;
        logic [AW-1:0] isr;
        logic          pcv;
        logic [AW-1:0] pc;
        logic [NS-1:0] e_stall;
        logic [NS-1:0] e_flush;
        logic          e_red;
        logic [AW-1:0] e_npc;
        logic          e_pend;
        logic [AW-1:0] e_pco;
    } vec_t;

    vec_t tbl[22];
    vec_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [NS-1:0] req, logic jen, logic [AW-1:0] jaddr,
                                logic ien, logic [AW-1:0] isr, logic pcv, logic [AW-1:0] pc,
                                logic [NS-1:0] e_stall, logic [NS-1:0] e_flush, logic e_red,
                                logic [AW-1:0] e_npc, logic e_pend, logic [AW-1:0] e_pco);
        vec_t v;
        v.req = req; v.jen = jen; v.jaddr = jaddr; v.ien = ien; v.isr = isr;
        v.pcv = pcv; v.pc = pc; v.e_stall = e_stall; v.e_flush = e_flush;
        v.e_red = e_red; v.e_npc = e_npc; v.e_pend = e_pend; v.e_pco = e_pco;
        return v;
    endfunction

    task automatic drive_idle();
        bus.stall_req_i   = '0;
        bus.jump_enable_i = 1'b0;
        bus.jump_addr_i   = '0;
        bus.int_en_i      = 1'b0;
        bus.isr_pc_i      = '0;
        bus.pc_valid_i    = 1'b0;
        bus.pc_i          = '0;
        timeout_clr_i     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sb_check(input int idx);
        vec_t e;
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d_sb_empty", idx), 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d_stall", idx), 64'(bus.stall_o), 64'(e.e_stall));
            check($sformatf("v%0d_flush", idx), 64'(bus.flush_o), 64'(e.e_flush));
            check($sformatf("v%0d_redirect", idx), 64'(bus.redirect_o), 64'(e.e_red));
            check($sformatf("v%0d_new_pc", idx), 64'(bus.new_pc_o), 64'(e.e_npc));
            check($sformatf("v%0d_pending", idx), 64'(bus.jump_pending_o), 64'(e.e_pend));
            check($sformatf("v%0d_pc_o", idx), 64'(bus.pc_o), 64'(e.e_pco));
        end
    endtask

    initial begin
        //          req       jen jaddr   ien isr    pcv pc       stall     flush     red npc     pend pc_o
        tbl[0]  = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000000,0, 32'h0,   0, RPC);
        tbl[1]  = mk(6'b000100,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000111,6'b000000,0, 32'h0,   0, RPC);
        tbl[2]  = mk(6'b001000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b001111,6'b000000,0, 32'h0,   0, RPC);
        tbl[3]  = mk(6'b100000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b111111,6'b000000,0, 32'h0,   0, RPC);
        tbl[4]  = mk(6'b000000,0, 32'h0,   0, 32'h0,  1, 32'h40, 6'b000000,6'b000000,0, 32'h0,   0, 32'h40);
        tbl[5]  = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000000,0, 32'h0,   0, 32'h40);
        tbl[6]  = mk(6'b000000,1, 32'h100, 0, 32'h0,  0, 32'h0,  6'b000000,6'b000110,1, 32'h100, 0, 32'h40);
        tbl[7]  = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000000,0, 32'h0,   0, 32'h100);
        tbl[8]  = mk(6'b000010,1, 32'h100, 0, 32'h0,  1, 32'h44, 6'b000000,6'b000110,1, 32'h100, 0, 32'h44);
        tbl[9]  = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000000,0, 32'h0,   0, 32'h44);
        tbl[10] = mk(6'b010100,1, 32'h180, 0, 32'h0,  0, 32'h0,  6'b011111,6'b000000,0, 32'h0,   0, 32'h44);
        tbl[11] = mk(6'b010000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b011111,6'b000000,0, 32'h0,   1, 32'h44);
        tbl[12] = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000110,1, 32'h180, 1, 32'h44);
        tbl[13] = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000000,0, 32'h0,   0, 32'h180);
        tbl[14] = mk(6'b001000,1, 32'h200, 0, 32'h0,  0, 32'h0,  6'b001111,6'b000000,0, 32'h0,   0, 32'h180);
        tbl[15] = mk(6'b001000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b001111,6'b000000,0, 32'h0,   1, 32'h180);
        tbl[16] = mk(6'b001000,1, 32'h300, 0, 32'h0,  0, 32'h0,  6'b001111,6'b000000,0, 32'h0,   1, 32'h180);
        tbl[17] = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000110,1, 32'h300, 1, 32'h180);
        tbl[18] = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000000,0, 32'h0,   0, 32'h300);
        tbl[19] = mk(6'b001000,1, 32'h400, 0, 32'h0,  0, 32'h0,  6'b001111,6'b000000,0, 32'h0,   0, 32'h300);
        tbl[20] = mk(6'b001000,1, 32'h500, 1, 32'h80, 0, 32'h0,  6'b000000,6'b111110,1, 32'h80,  1, 32'h300);
        tbl[21] = mk(6'b000000,0, 32'h0,   0, 32'h0,  0, 32'h0,  6'b000000,6'b000000,0, 32'h0,   0, 32'h80);

        drive_idle();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();

        foreach (tbl[i]) begin
            bus.stall_req_i   = tbl[i].req;
            bus.jump_enable_i = tbl[i].jen;
            bus.jump_addr_i   = tbl[i].jaddr;
            bus.int_en_i      = tbl[i].ien;
            bus.isr_pc_i      = tbl[i].isr;
            bus.pc_valid_i    = tbl[i].pcv;
            bus.pc_i          = tbl[i].pc;
            sb_q.push_back(tbl[i]);
            @(negedge clk_i);
            sb_check(i);
            next_cycle();
        end
        drive_idle();
        @(negedge clk_i);
        check("tbl_stall_cycles", 64'(stall_cycles_o), 64'd9);
        check("tbl_flush_count", 64'(flush_count_o), 64'd5);
        check("tbl_no_timeout", 64'(stall_timeout_o), 64'd0);

        // Reset asserted while a jump is held.
        next_cycle();
        bus.stall_req_i   = 6'b001000;
        bus.jump_enable_i = 1'b1;
        bus.jump_addr_i   = 32'h600;
        next_cycle();
        bus.jump_enable_i = 1'b0;
        @(negedge clk_i);
        check("rst_pre_pending", 64'(bus.jump_pending_o), 64'd1);
        drive_idle();
        #1 rst_ni = 1'b0;
        #1;
        check("rst_pending", 64'(bus.jump_pending_o), 64'd0);
        check("rst_pc_o", 64'(bus.pc_o), 64'(RPC));
        check("rst_redirect", 64'(bus.redirect_o), 64'd0);
        check("rst_stall_cycles", 64'(stall_cycles_o), 64'd0);
        check("rst_flush_count", 64'(flush_count_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
        @(negedge clk_i);
        check("post_rst_pending", 64'(bus.jump_pending_o), 64'd0);
        check("post_rst_stall", 64'(bus.stall_o), 64'd0);
        check("post_rst_flush", 64'(bus.flush_o), 64'd0);
        check("post_rst_new_pc", 64'(bus.new_pc_o), 64'd0);
        check("post_rst_pc_o", 64'(bus.pc_o), 64'(RPC));
        check("post_rst_timeout", 64'(stall_timeout_o), 64'd0);

        // Watchdog: six PC-stall cycles, flag visible from the fifth.
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            bus.stall_req_i = 6'b000010;
            @(negedge clk_i);
            check($sformatf("wd_flag_c%0d", i), 64'(stall_timeout_o), 64'(i >= 4));
        end
        next_cycle();
        bus.stall_req_i = '0;
        @(negedge clk_i);
        check("wd_sticky", 64'(stall_timeout_o), 64'd1);
        check("wd_stall_cycles", 64'(stall_cycles_o), 64'd6);
        next_cycle();
        timeout_clr_i = 1'b1;
        @(negedge clk_i);
        check("wd_before_clr", 64'(stall_timeout_o), 64'd1);
        next_cycle();
        timeout_clr_i = 1'b0;
        @(negedge clk_i);
        check("wd_cleared", 64'(stall_timeout_o), 64'd0);

        // Interrupt clears the flag.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.stall_req_i = 6'b000010;
        end
        next_cycle();
        bus.stall_req_i = '0;
        bus.int_en_i    = 1'b1;
        bus.isr_pc_i    = 32'h80;
        @(negedge clk_i);
        check("int_flag_set", 64'(stall_timeout_o), 64'd1);
        check("int_new_pc", 64'(bus.new_pc_o), 64'h80);
        next_cycle();
        drive_idle();
        @(negedge clk_i);
        check("int_flag_cleared", 64'(stall_timeout_o), 64'd0);
        check("int_stall_cycles", 64'(stall_cycles_o), 64'd10);

        // Long stall saturates stall_cycles; clear wins over a same-cycle set.
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            bus.stall_req_i = 6'b000010;
            timeout_clr_i   = (i == 7);
        end
        next_cycle();
        drive_idle();
        @(negedge clk_i);
        check("clr_wins", 64'(stall_timeout_o), 64'd0);
        check("sat_stall_cycles", 64'(stall_cycles_o), 64'd15);
        check("sat_flush_count", 64'(flush_count_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
